lda_avalon_ctrl: RTL and testbench

LDA_AVALON_CTRL -- requirements
Module: lda_avalon_ctrl

---
 rtl/lda_pkg.sv | 26 ++
 rtl/lda_avalon_if.sv | 22 ++
 rtl/lda_regfile.sv | 69 ++++++
 rtl/lda_avalon_ctrl.sv | 80 ++++++++
 tb/tb_lda_avalon_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lda_pkg.sv
// Shared types and constants for the line-draw Avalon-MM controller.
package lda_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 3;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } lda_state_t;

  localparam logic MODE_STALL = 1'b0;
  localparam logic MODE_POLL  = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_MODE   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_GO     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_START  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_END    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_COLOR  = 3'd5;

endpackage

// File: rtl/lda_avalon_if.sv
// Avalon-MM slave bus bundle for the line-draw controller.
interface lda_avalon_if;
  import lda_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/lda_regfile.sv
// Register storage for MODE/START/END/COLOR, busy write masking and the
// zero-latency readdata mux.
module lda_regfile
  import lda_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address,
  input  logic               wr_accept,
  input  logic [DATA_W-1:0]  writedata,
  input  logic               busy,
  output logic [DATA_W-1:0]  readdata,
  output logic               mode,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COLOR_W-1:0] color
);

  logic                 mode_reg;
  logic [2*COORD_W-1:0] start_reg;
  logic [2*COORD_W-1:0] end_reg;
  logic [COLOR_W-1:0]   color_reg;
  logic                 wr_en;

  // In poll mode the master never stalls, so the register file itself
  // must protect the operands of a draw in flight.
  assign wr_en = wr_accept && !((mode_reg == MODE_POLL) && busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg  <= MODE_STALL;
      start_reg <= '0;
      end_reg   <= '0;
      color_reg <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_MODE:  mode_reg  <= writedata[0];
        ADDR_START: start_reg <= writedata[2*COORD_W-1:0];
        ADDR_END:   end_reg   <= writedata[2*COORD_W-1:0];
        ADDR_COLOR: color_reg <= writedata[COLOR_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_MODE:   readdata[0]             = mode_reg;
      ADDR_STATUS: readdata[0]             = busy;
      ADDR_START:  readdata[2*COORD_W-1:0] = start_reg;
      ADDR_END:    readdata[2*COORD_W-1:0] = end_reg;
      ADDR_COLOR:  readdata[COLOR_W-1:0]   = color_reg;
      default: ;
    endcase
  end

  assign mode  = mode_reg;
  assign x0    = start_reg[COORD_W-1:0];
  assign y0    = start_reg[2*COORD_W-1:COORD_W];
  assign x1    = end_reg[COORD_W-1:0];
  assign y1    = end_reg[2*COORD_W-1:COORD_W];
  assign color = color_reg;

  wire unused_wdata = ^writedata[DATA_W-1:2*COORD_W];

endmodule

// File: rtl/lda_avalon_ctrl.sv
// Avalon-MM front end for a line-draw datapath: launch FSM, stall/poll
// handshake and register file.
module lda_avalon_ctrl
  import lda_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  lda_avalon_if.slave        avs,
  output logic               o_START,
  output logic               o_RUN,
  input  logic               i_CONDITION,
  output logic [COORD_W-1:0] o_X0,
  output logic [COORD_W-1:0] o_Y0,
  output logic [COORD_W-1:0] o_X1,
  output logic [COORD_W-1:0] o_Y1,
  output logic [COLOR_W-1:0] o_COLOR
);

  lda_state_t state_reg, state_next;
  logic       start_reg, run_reg;
  logic       mode;
  logic       busy;
  logic       wait_req;
  logic       go_write;

  assign busy = (state_reg != S_IDLE);

  // In stall mode the launching GO write is taken in IDLE; if the master
  // keeps it asserted it is held through START/RUN and retires in DONE.
  assign wait_req = (mode == MODE_STALL)
                 && ((state_reg == S_START) || (state_reg == S_RUN))
                 && (avs.avs_read || avs.avs_write);

  assign go_write = (state_reg == S_IDLE) && avs.avs_write && !wait_req
                 && (avs.avs_address == ADDR_GO);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (go_write) state_next = S_START;
      S_START: state_next = S_RUN;
      S_RUN:   if (i_CONDITION) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      start_reg <= 1'b0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= (state_next == S_START);
      run_reg   <= (state_next == S_RUN);
    end
  end

  assign o_START             = start_reg;
  assign o_RUN               = run_reg;
  assign avs.avs_waitrequest = wait_req;

  lda_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .address   (avs.avs_address),
    .wr_accept (avs.avs_write && !wait_req),
    .writedata (avs.avs_writedata),
    .busy      (busy),
    .readdata  (avs.avs_readdata),
    .mode      (mode),
    .x0        (o_X0),
    .y0        (o_Y0),
    .x1        (o_X1),
    .y1        (o_Y1),
    .color     (o_COLOR)
  );

endmodule

// File: tb/tb_lda_avalon_ctrl.sv
// Self-checking bench for lda_avalon_ctrl with a register-level reference model.
module tb_lda_avalon_ctrl;
  import lda_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       o_START, o_RUN;
  logic       i_CONDITION;
  logic [8:0] o_X0, o_Y0, o_X1, o_Y1;
  logic [2:0] o_COLOR;
  int         vectors = 0;
  int         errors = 0;

  lda_avalon_if bus();

  always #5 clk = ~clk;

  lda_avalon_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .avs         (bus.slave),
    .o_START     (o_START),
    .o_RUN       (o_RUN),
    .i_CONDITION (i_CONDITION),
    .o_X0        (o_X0),
    .o_Y0        (o_Y0),
    .o_X1        (o_X1),
    .o_Y1        (o_Y1),
    .o_COLOR     (o_COLOR)
  );

  // Reference register contents, kept as named fields.
  logic       m_mode;
  logic [8:0] m_x0, m_y0, m_x1, m_y1;
  logic [2:0] m_color;

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic busy);
    case (a)
      3'd0:    return {31'd0, m_mode};
      3'd1:    return {31'd0, busy};
      3'd3:    return {14'd0, m_y0, m_x0};
      3'd4:    return {14'd0, m_y1, m_x1};
      3'd5:    return {29'd0, m_color};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: m_mode = d[0];
      3'd3: begin m_x0 = d[8:0]; m_y0 = d[17:9]; end
      3'd4: begin m_x1 = d[8:0]; m_y1 = d[17:9]; end
      3'd5: m_color = d[2:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_x0 = '0; m_y0 = '0; m_x1 = '0; m_y1 = '0; m_color = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    step();
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    #2;
    while (bus.avs_waitrequest === 1'b1 && n < 100) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 100) begin
      vectors++; errors++;
      $display("FAIL bus_write_timeout: addr=%0d waitrequest still %b", a, bus.avs_waitrequest);
    end
    step();
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    int n = 0;
    step();
    bus.avs_address = a; bus.avs_read = 1'b1;
    #2;
    while (bus.avs_waitrequest === 1'b1 && n < 100) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 100) begin
      vectors++; errors++;
      $display("FAIL bus_read_timeout: addr=%0d waitrequest still %b", a, bus.avs_waitrequest);
    end
    d = bus.avs_readdata;
    step();
    bus.avs_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (2) step();
    bus.avs_read = 1'b1; bus.avs_address = ADDR_MODE;
    #2;
    vectors++;
    if ({o_START, o_RUN, bus.avs_waitrequest} !== 3'b000)
      begin errors++; $display("FAIL reset_ctrl: start/run/wait=%b required 000", {o_START, o_RUN, bus.avs_waitrequest}); end
    vectors++;
    if ({o_X0, o_Y0, o_X1, o_Y1, o_COLOR} !== 39'd0)
      begin errors++; $display("FAIL reset_coords: got %h required 0", {o_X0, o_Y0, o_X1, o_Y1, o_COLOR}); end
    vectors++;
    if (bus.avs_readdata !== 32'd0)
      begin errors++; $display("FAIL reset_mode: readdata=%h required 0", bus.avs_readdata); end
    step();
    bus.avs_read = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], rd);
      vectors++;
      if (rd !== model_read(a[2:0], 1'b0))
        begin errors++; $display("FAIL reset_read: addr=%0d got %h required %h", a, rd, model_read(a[2:0], 1'b0)); end
      $display("reset read addr=%0d data=%h", a, rd);
    end
  endtask

  task automatic test_regs_random();
    logic [31:0] rd, d;
    logic [2:0]  a, ra;
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      if (a == ADDR_GO) a = ADDR_COLOR;
      d = $urandom;
      bus_write(a, d);
      model_write(a, d);
      ra = 3'($urandom_range(0, 7));
      bus_read(ra, rd);
      vectors++;
      if (rd !== model_read(ra, 1'b0))
        begin errors++; $display("FAIL reg_read: wr addr=%0d rd addr=%0d got %h required %h", a, ra, rd, model_read(ra, 1'b0)); end
      vectors++;
      if ({o_X0, o_Y0, o_X1, o_Y1, o_COLOR} !== {m_x0, m_y0, m_x1, m_y1, m_color})
        begin errors++; $display("FAIL reg_outputs: got %h required %h", {o_X0, o_Y0, o_X1, o_Y1, o_COLOR}, {m_x0, m_y0, m_x1, m_y1, m_color}); end
      $display("reg write addr=%0d data=%h, read addr=%0d data=%h", a, d, ra, rd);
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] rd, old_v;
    logic [31:0] newc;
    newc = {29'd0, ~m_color};
    old_v = model_read(ADDR_COLOR, 1'b0);
    step();
    bus.avs_address = ADDR_COLOR; bus.avs_read = 1'b1; bus.avs_write = 1'b1; bus.avs_writedata = newc;
    #2;
    vectors++;
    if (bus.avs_readdata !== old_v)
      begin errors++; $display("FAIL rw_same_cycle: readdata=%h required pre-write %h", bus.avs_readdata, old_v); end
    step();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    model_write(ADDR_COLOR, newc);
    bus_read(ADDR_COLOR, rd);
    vectors++;
    if (rd !== model_read(ADDR_COLOR, 1'b0))
      begin errors++; $display("FAIL rw_after: got %h required %h", rd, model_read(ADDR_COLOR, 1'b0)); end
    $display("simultaneous rw colour old=%h new=%h", old_v, rd);
  endtask

  task automatic test_poll_draw(input logic [8:0] x0, input logic [8:0] y0, input logic [8:0] x1,
                                input logic [8:0] y1, input logic [2:0] col, input int run_len,
                                input bit busy_writes);
    logic [31:0] rd;
    logic [17:0] end_before;
    bus_write(ADDR_MODE, 32'd1);               model_write(ADDR_MODE, 32'd1);
    bus_write(ADDR_START, {14'd0, y0, x0});    model_write(ADDR_START, {14'd0, y0, x0});
    bus_write(ADDR_END, {14'd0, y1, x1});      model_write(ADDR_END, {14'd0, y1, x1});
    bus_write(ADDR_COLOR, {29'd0, col});       model_write(ADDR_COLOR, {29'd0, col});
    end_before = {m_y1, m_x1};
    bus_write(ADDR_GO, $urandom);
    // START cycle: a stray i_CONDITION here must not shorten the draw.
    i_CONDITION = 1'($urandom_range(0, 1));
    bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    #2;
    vectors++;
    if ({o_START, o_RUN} !== 2'b10)
      begin errors++; $display("FAIL poll_start: start/run=%b required 10", {o_START, o_RUN}); end
    vectors++;
    if ({o_X0, o_Y0, o_X1, o_Y1, o_COLOR} !== {x0, y0, x1, y1, col})
      begin errors++; $display("FAIL poll_operands: got %h required %h", {o_X0, o_Y0, o_X1, o_Y1, o_COLOR}, {x0, y0, x1, y1, col}); end
    vectors++;
    if (bus.avs_readdata !== 32'd1)
      begin errors++; $display("FAIL poll_status_start: got %h required 1", bus.avs_readdata); end
    for (int k = 1; k <= run_len; k++) begin
      step();
      i_CONDITION = (k == run_len);
      if (busy_writes && k == 1) begin
        bus.avs_read = 1'b0; bus.avs_write = 1'b1; bus.avs_address = ADDR_END; bus.avs_writedata = 32'd0;
      end else begin
        bus.avs_write = 1'b0; bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
      end
      #2;
      vectors++;
      if ({o_START, o_RUN, bus.avs_waitrequest} !== 3'b010)
        begin errors++; $display("FAIL poll_run: cycle %0d start/run/wait=%b required 010", k, {o_START, o_RUN, bus.avs_waitrequest}); end
      vectors++;
      if ({o_Y1, o_X1} !== end_before)
        begin errors++; $display("FAIL poll_end_stable: got %h required %h", {o_Y1, o_X1}, end_before); end
      if (bus.avs_read) begin
        vectors++;
        if (bus.avs_readdata !== 32'd1)
          begin errors++; $display("FAIL poll_status_run: got %h required 1", bus.avs_readdata); end
      end
    end
    step();
    i_CONDITION = 1'b0;
    if (busy_writes) begin
      bus.avs_read = 1'b0; bus.avs_write = 1'b1; bus.avs_address = ADDR_GO;
    end else begin
      bus.avs_write = 1'b0; bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    end
    #2;
    vectors++;
    if ({o_START, o_RUN} !== 2'b00)
      begin errors++; $display("FAIL poll_done: start/run=%b required 00", {o_START, o_RUN}); end
    if (!busy_writes) begin
      vectors++;
      if (bus.avs_readdata !== 32'd1)
        begin errors++; $display("FAIL poll_status_done: got %h required 1", bus.avs_readdata); end
    end
    step();
    bus.avs_write = 1'b0; bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    #2;
    vectors++;
    if ({bus.avs_readdata, o_START, o_RUN} !== 34'd0)
      begin errors++; $display("FAIL poll_idle: status=%h start/run=%b required 0/00", bus.avs_readdata, {o_START, o_RUN}); end
    step();
    #2;
    vectors++;
    if ({o_START, o_RUN} !== 2'b00)
      begin errors++; $display("FAIL poll_no_relaunch: start/run=%b required 00", {o_START, o_RUN}); end
    bus.avs_read = 1'b0;
    bus_read(ADDR_END, rd);
    vectors++;
    if (rd !== model_read(ADDR_END, 1'b0))
      begin errors++; $display("FAIL poll_end_readback: got %h required %h", rd, model_read(ADDR_END, 1'b0)); end
    $display("poll draw (%0d,%0d)->(%0d,%0d) col=%0d run=%0d busy_writes=%0b", x0, y0, x1, y1, col, run_len, busy_writes);
  endtask

  task automatic test_stall_draw();
    int starts = 0, waits = 0, runs = 0;
    bit done_seen = 0;
    bus_write(ADDR_MODE, 32'd0);  model_write(ADDR_MODE, 32'd0);
    step();
    bus.avs_address = ADDR_GO; bus.avs_writedata = $urandom; bus.avs_write = 1'b1;
    #2;
    vectors++;
    if ({bus.avs_waitrequest, o_START} !== 2'b00)
      begin errors++; $display("FAIL stall_launch: wait/start=%b required 00", {bus.avs_waitrequest, o_START}); end
    for (int c = 0; c < 40 && !done_seen; c++) begin
      step();
      i_CONDITION = 1'b0;
      #2;
      if (o_START) starts++;
      if (bus.avs_waitrequest) waits++;
      else begin
        done_seen = 1;
        vectors++;
        if (o_RUN !== 1'b0)
          begin errors++; $display("FAIL stall_done_run: o_RUN=%b required 0", o_RUN); end
      end
      if (o_RUN) begin runs++; if (runs == 4) i_CONDITION = 1'b1; end
    end
    step();
    bus.avs_write = 1'b0; i_CONDITION = 1'b0;
    bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    for (int c = 0; c < 3; c++) begin
      #2;
      if (o_START) starts++;
      vectors++;
      if (bus.avs_readdata !== 32'd0)
        begin errors++; $display("FAIL stall_after_status: got %h required 0", bus.avs_readdata); end
      step();
    end
    bus.avs_read = 1'b0;
    vectors++;
    if (!done_seen)
      begin errors++; $display("FAIL stall_timeout: waitrequest never dropped"); end
    vectors++;
    if (waits !== 5)
      begin errors++; $display("FAIL stall_wait_cycles: got %0d required 5", waits); end
    vectors++;
    if (starts !== 1)
      begin errors++; $display("FAIL stall_start_pulses: got %0d required 1", starts); end
    vectors++;
    if (runs !== 4)
      begin errors++; $display("FAIL stall_run_cycles: got %0d required 4", runs); end
    $display("stall draw waits=%0d starts=%0d runs=%0d", waits, starts, runs);
  endtask

  task automatic test_stall_status(input int run_len);
    int waits = 0, runs = 0;
    bit done_seen = 0;
    bus_write(ADDR_GO, $urandom);
    bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (c != 0) step();
      i_CONDITION = 1'b0;
      #2;
      if (bus.avs_waitrequest) waits++;
      else begin
        done_seen = 1;
        vectors++;
        if (bus.avs_readdata !== 32'd1)
          begin errors++; $display("FAIL stall_status_value: got %h required 1", bus.avs_readdata); end
      end
      if (o_RUN) begin runs++; if (runs == run_len) i_CONDITION = 1'b1; end
    end
    step();
    bus.avs_read = 1'b0; i_CONDITION = 1'b0;
    vectors++;
    if (!done_seen || waits !== run_len + 1)
      begin errors++; $display("FAIL stall_status_wait: done=%0b waits=%0d required %0d", done_seen, waits, run_len + 1); end
    $display("stall status read run=%0d waits=%0d", run_len, waits);
  endtask

  task automatic test_cond_idle();
    step();
    bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    for (int c = 0; c < 4; c++) begin
      i_CONDITION = 1'b1;
      #2;
      vectors++;
      if ({bus.avs_readdata, o_START, o_RUN} !== 34'd0)
        begin errors++; $display("FAIL cond_idle: status=%h start/run=%b required 0/00", bus.avs_readdata, {o_START, o_RUN}); end
      step();
    end
    i_CONDITION = 1'b0; bus.avs_read = 1'b0;
    $display("i_CONDITION in idle ignored");
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    bus_write(ADDR_MODE, 32'd1);  model_write(ADDR_MODE, 32'd1);
    bus_write(ADDR_GO, $urandom);
    step();
    bus.avs_read = 1'b1; bus.avs_address = ADDR_STATUS;
    #2;
    vectors++;
    if (o_RUN !== 1'b1)
      begin errors++; $display("FAIL midrun_pre: o_RUN=%b required 1", o_RUN); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({o_START, o_RUN, bus.avs_waitrequest} !== 3'b000 || bus.avs_readdata !== 32'd0)
      begin errors++; $display("FAIL midrun_abort: start/run/wait=%b status=%h required 000/0", {o_START, o_RUN, bus.avs_waitrequest}, bus.avs_readdata); end
    step(); step();
    reset = 1'b0; bus.avs_read = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #2;
      vectors++;
      if ({o_START, o_RUN} !== 2'b00)
        begin errors++; $display("FAIL midrun_after: start/run=%b required 00", {o_START, o_RUN}); end
      step();
    end
    bus_read(ADDR_MODE, rd);
    vectors++;
    if (rd !== model_read(ADDR_MODE, 1'b0))
      begin errors++; $display("FAIL midrun_mode: got %h required %h", rd, model_read(ADDR_MODE, 1'b0)); end
    $display("reset mid-run, mode after=%h", rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    i_CONDITION = 1'b0;
    model_reset();
    test_reset();
    test_regs_random();
    test_rw_same_cycle();
    test_poll_draw(9'd10, 9'd20, 9'd13, 9'd20, 3'd5, 4, 1'b0);
    test_poll_draw(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 3'($urandom), $urandom_range(1, 6), 1'b1);
    test_stall_draw();
    for (int i = 0; i < 3; i++) test_stall_status($urandom_range(1, 6));
    test_cond_idle();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
